// File: rtl/alu4_pkg.sv
// Shared opcodes, FSM state encoding and default width for the alu4 accumulator stage.
package alu4_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu4_shift_mul.sv
// Shift-add multiplier; only instantiated when ALU4_MUL_EN is defined.
// The first partial product is formed on start, so done pulses WIDTH-1 cycles later.
module alu4_shift_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                prod_q   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand_q  <= {{WIDTH{1'b0}}, a} << 1;
                mplier_q <= b >> 1;
                cnt_q    <= CW'(WIDTH - 1);
                busy_q   <= (WIDTH > 1);
                done_q   <= (WIDTH == 1);
            end else if (busy_q) begin
                if (mplier_q[0]) begin
                    prod_q <= prod_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign product = prod_q;
    assign done    = done_q;

endmodule

// File: rtl/alu4_acc_unit.sv
// Accumulator/execute stage of the 4-bit ALU with valid/ready on both sides.
// Define ALU4_MUL_EN to build the multi-cycle MUL opcode; otherwise opcode 110 is reserved.
module alu4_acc_unit
    import alu4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign sum  = {1'b0, acc_q} + {1'b0, operand};
    assign diff = {1'b0, acc_q} - {1'b0, operand};

`ifdef ALU4_MUL_EN
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_done;
    logic               mul_start;

    assign mul_start = in_valid && (state_q == IDLE) && (op == OP_MUL);

    alu4_shift_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (acc_q),
        .b       (operand),
        .product (mul_product),
        .done    (mul_done)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    // Result registers only change on the transition into DONE; everywhere else they hold.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    case (op)
                        OP_LOAD: begin
                            acc_d   = operand;
                            carry_d = 1'b0;
                        end
                        OP_ADD: begin
                            acc_d   = sum[WIDTH-1:0];
                            carry_d = sum[WIDTH];
                        end
                        OP_SUB: begin
                            acc_d   = diff[WIDTH-1:0];
                            carry_d = diff[WIDTH];
                        end
                        OP_AND: begin
                            acc_d   = acc_q & operand;
                            carry_d = 1'b0;
                        end
                        OP_OR: begin
                            acc_d   = acc_q | operand;
                            carry_d = 1'b0;
                        end
                        OP_XOR: begin
                            acc_d   = acc_q ^ operand;
                            carry_d = 1'b0;
                        end
`ifdef ALU4_MUL_EN
                        OP_MUL: begin
                            state_d = EXEC;
                            err_d   = err_q;
                        end
`endif
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
`ifdef ALU4_MUL_EN
            EXEC: begin
                if (mul_done) begin
                    state_d = DONE;
                    acc_d   = mul_product[WIDTH-1:0];
                    carry_d = |mul_product[2*WIDTH-1:WIDTH];
                    err_d   = 1'b0;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign zero_d    = (acc_d == '0);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign acc       = acc_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu4_acc_unit.sv
// Directed self-checking bench for alu4_acc_unit; expectations follow ALU4_MUL_EN when defined.
module tb_alu4_acc_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] operand;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] acc;
    logic       carry;
    logic       zero;
    logic       err;

    int errors = 0;
    int checks = 0;

    alu4_acc_unit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one op for a single edge, then counts negedges until out_valid shows (bounded).
    task automatic run_op(input logic [2:0] o, input logic [3:0] d, output int lat);
        @(negedge clk);
        op       = o;
        operand  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 3'b000;
        operand = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({acc, carry, zero, err, out_valid, in_ready} !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset: got acc=%h c=%b z=%b e=%b ov=%b ir=%b, expected acc=0 c=0 z=1 e=0 ov=0 ir=1",
                     acc, carry, zero, err, out_valid, in_ready);
        end
    endtask

    task automatic test_load();
        int lat;
        run_op(3'b000, 4'h9, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("[TB] FAIL load_latency: got %0d expected 1", lat);
        end
        checks++;
        if ({acc, carry, zero, err} !== {4'h9, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL load_result: got acc=%h c=%b z=%b e=%b expected acc=9 c=0 z=0 e=0", acc, carry, zero, err);
        end
        pop();
    endtask

    task automatic test_add();
        int lat;
        run_op(3'b001, 4'h8, lat);
        checks++;
        if ({acc, carry, zero} !== {4'h1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_carry: got acc=%h c=%b z=%b expected acc=1 c=1 z=0", acc, carry, zero);
        end
        pop();
        run_op(3'b001, 4'h0, lat);
        checks++;
        if ({acc, carry, zero} !== {4'h1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_zero_operand: got acc=%h c=%b z=%b expected acc=1 c=0 z=0", acc, carry, zero);
        end
        pop();
    endtask

    task automatic test_sub();
        int lat;
        run_op(3'b000, 4'h3, lat);
        pop();
        run_op(3'b010, 4'h5, lat);
        checks++;
        if ({acc, carry, zero} !== {4'hE, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sub_borrow: got acc=%h c=%b z=%b expected acc=e c=1 z=0", acc, carry, zero);
        end
        pop();
        run_op(3'b000, 4'h3, lat);
        pop();
        run_op(3'b010, 4'h3, lat);
        checks++;
        if ({acc, carry, zero} !== {4'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL sub_to_zero: got acc=%h c=%b z=%b expected acc=0 c=0 z=1", acc, carry, zero);
        end
        pop();
    endtask

    task automatic test_logic();
        int lat;
        run_op(3'b000, 4'hC, lat);
        pop();
        run_op(3'b011, 4'hA, lat);
        checks++;
        if (acc !== 4'h8) begin
            errors++;
            $display("[TB] FAIL and: got %h expected 8", acc);
        end
        pop();
        run_op(3'b100, 4'h3, lat);
        checks++;
        if (acc !== 4'hB) begin
            errors++;
            $display("[TB] FAIL or: got %h expected b", acc);
        end
        pop();
        run_op(3'b101, 4'h6, lat);
        checks++;
        if (acc !== 4'hD) begin
            errors++;
            $display("[TB] FAIL xor: got %h expected d", acc);
        end
        pop();
        run_op(3'b001, 4'h4, lat);
        pop();
        run_op(3'b101, 4'h1, lat);
        checks++;
        if ({acc, carry, zero} !== {4'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL xor_clears_carry: got acc=%h c=%b z=%b expected acc=0 c=0 z=1", acc, carry, zero);
        end
        pop();
    endtask

    task automatic test_mul();
        int lat;
        run_op(3'b000, 4'h5, lat);
        pop();
        run_op(3'b110, 4'h3, lat);
`ifdef ALU4_MUL_EN
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("[TB] FAIL mul_latency: got %0d expected 5", lat);
        end
        checks++;
        if ({acc, carry, err} !== {4'hF, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mul_5x3: got acc=%h c=%b e=%b expected acc=f c=0 e=0", acc, carry, err);
        end
        pop();
        run_op(3'b000, 4'h6, lat);
        pop();
        run_op(3'b110, 4'h3, lat);
        checks++;
        if ({acc, carry, zero} !== {4'h2, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mul_6x3: got acc=%h c=%b z=%b expected acc=2 c=1 z=0", acc, carry, zero);
        end
`else
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("[TB] FAIL mul_disabled_latency: got %0d expected 1", lat);
        end
        checks++;
        if ({acc, carry, err} !== {4'h5, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mul_disabled: got acc=%h c=%b e=%b expected acc=5 c=0 e=1", acc, carry, err);
        end
`endif
        pop();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(3'b000, 4'hA, lat);
        op       = 3'b001;
        operand  = 4'h1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, acc, carry, zero, err} !== {1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL backpressure_hold[%0d]: got ov=%b ir=%b acc=%h c=%b z=%b e=%b expected ov=1 ir=0 acc=a c=0 z=0 e=0",
                         i, out_valid, in_ready, acc, carry, zero, err);
            end
        end
        in_valid = 1'b0;
        pop();
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, acc} !== {1'b0, 1'b1, 4'hA}) begin
            errors++;
            $display("[TB] FAIL backpressure_release: got ov=%b ir=%b acc=%h expected ov=0 ir=1 acc=a", out_valid, in_ready, acc);
        end
        run_op(3'b001, 4'h1, lat);
        checks++;
        if (acc !== 4'hB) begin
            errors++;
            $display("[TB] FAIL back_to_back_add: got %h expected b", acc);
        end
        pop();
    endtask

    task automatic test_reserved();
        int lat;
        run_op(3'b000, 4'h7, lat);
        pop();
        run_op(3'b111, 4'h2, lat);
        checks++;
        if ({lat[3:0], acc, carry, zero, err} !== {4'd1, 4'h7, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reserved: got lat=%0d acc=%h c=%b z=%b e=%b expected lat=1 acc=7 c=0 z=0 e=1",
                     lat, acc, carry, zero, err);
        end
        pop();
        run_op(3'b001, 4'h1, lat);
        checks++;
        if ({acc, err} !== {4'h8, 1'b0}) begin
            errors++;
            $display("[TB] FAIL err_clear: got acc=%h e=%b expected acc=8 e=0", acc, err);
        end
        pop();
    endtask

    task automatic test_reset_abort();
        int lat;
        run_op(3'b000, 4'h5, lat);
        pop();
        @(negedge clk);
`ifdef ALU4_MUL_EN
        op       = 3'b110;
        operand  = 4'h3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, acc} !== {1'b0, 1'b0, 4'h5}) begin
            errors++;
            $display("[TB] FAIL mul_exec_busy: got ov=%b ir=%b acc=%h expected ov=0 ir=0 acc=5", out_valid, in_ready, acc);
        end
`else
        op       = 3'b001;
        operand  = 4'h3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({acc, carry, zero, err, out_valid, in_ready} !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_abort: got acc=%h c=%b z=%b e=%b ov=%b ir=%b expected acc=0 c=0 z=1 e=0 ov=0 ir=1",
                     acc, carry, zero, err, out_valid, in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_no_valid[%0d]: got %b expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_sub();
        test_logic();
        test_mul();
        test_backpressure();
        test_reserved();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu4_acc_unit.md
# alu4_acc_unit

Sequential accumulator/execute stage of the 4-bit ALU, directly downstream of the MUX_21 operand-select stage. Consumes the selected operand plus a 3-bit opcode over a valid/ready handshake. Applies it to an internal accumulator, then presents the result and flags over a second valid/ready handshake. Single-cycle logic/arithmetic ops, plus an optional multi-cycle shift-add multiply.

## Interface
- WIDTH, 4, accumulator/operand width in bits
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  op/operand present
- in_ready  out  1  block can accept; high only in IDLE
- op  in  3  opcode (see Operation)
- operand  in  WIDTH  operand from MUX_21 stage output
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- acc  out  WIDTH  accumulator value
- carry  out  1  carry / borrow / multiply-overflow flag
- zero  out  1  acc == 0
- err  out  1  last accepted opcode was illegal

## Operation
- Accept = in_valid & in_ready. op/operand are sampled only on accept.
- Opcodes:
  - 000 LOAD: acc=operand, carry=0
  - 001 ADD: {carry,acc}=acc+operand
  - 010 SUB: acc=acc-operand mod 2^WIDTH, carry=1 iff acc<operand (borrow)
  - 011 AND, 100 OR, 101 XOR: bitwise; carry=0
  - 110 MUL: acc=low WIDTH bits of acc*operand; carry=1 iff high WIDTH bits nonzero
  - 111: reserved
- FSM states: IDLE, EXEC, DONE.
  - IDLE -> DONE on accept of any non-MUL op.
  - IDLE -> EXEC on accept of MUL.
  - EXEC -> DONE after WIDTH iterations of the multiplier.
  - DONE -> IDLE when out_ready=1.
- Reserved opcode: err=1; acc and carry unchanged; zero recomputed; goes to DONE.
- err is cleared on every accept of a legal opcode.
- acc, carry, zero and err update only on the edge entering DONE. They are stable in IDLE, EXEC and DONE otherwise.
- MUL keeps its partial product in a separate register. acc is not disturbed during EXEC.
- zero is registered together with acc, never computed combinationally on stale data.
- in_valid is ignored outside IDLE; there is no queueing.

## Timing
- Reset values: acc=0, carry=0, zero=1, err=0, out_valid=0, state IDLE. in_ready=1 in the first cycle after reset deasserts.
- Non-MUL latency: accept on edge N -> out_valid=1 from edge N+1.
- MUL latency: accept on edge N -> out_valid=1 from edge N+WIDTH+1.
- out_valid holds until the out_ready=1 edge. Then out_valid=0 and in_ready=1 on the next cycle.
- Peak throughput is one op per 2 cycles (non-MUL) and one per WIDTH+2 cycles (MUL).
- Reset mid-operation (EXEC or DONE) aborts the op: all outputs take reset values and no out_valid is issued for the aborted op.
- out_ready is ignored outside DONE.

## Configuration
- Macro ALU4_MUL_EN.
- Defined: MUL opcode 110 is implemented as above, including the EXEC state and multiplier sub-module.
- Undefined: opcode 110 behaves exactly like 111: err=1, single-cycle, acc unchanged. The EXEC state and multiplier logic are not compiled.

## Structure
- Package alu4_pkg holds:
  - opcode localparams (OP_LOAD … OP_RSVD)
  - FSM state encoding (IDLE, EXEC, DONE)
  - default WIDTH constant
- Sub-module alu4_shift_mul holds the shift-add multiplier:
  - start, operands, and a WIDTH-cycle iteration counter
  - outputs: 2·WIDTH product and done pulse
  - present only under ALU4_MUL_EN

## Test plan
- Reset, then LOAD 4'h9 -> out_valid one cycle after accept, acc=9, carry=0, zero=0, err=0.
- acc=9, ADD 4'h8 -> acc=4'h1, carry=1. Then ADD 4'h0 -> acc=1, carry=0.
- acc=3, SUB 4'h5 -> acc=4'hE, carry=1. LOAD 3 then SUB 3 -> acc=0, zero=1, carry=0.
- MUL with ALU4_MUL_EN, WIDTH=4:
  - acc=5, operand=3 -> out_valid exactly 5 cycles after accept, acc=4'hF, carry=0.
  - acc=6, operand=3 -> acc=4'h2, carry=1.
  - Without the macro: op 110 -> err=1, acc unchanged, 1-cycle latency.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, acc and flags stable, in_ready=0. in_valid pulses during this time are not accepted.
- Reserved op 111 from acc=7 -> err=1, acc=7. Then assert rst during MUL EXEC -> acc=0, zero=1, out_valid stays 0.
